// File: rtl/cbd_ctrl_if.sv
// Bus bundle between cbd_ctrl and its environment: start/config, PRF stream,
// cbd sampler port, polynomial RAM write port and status.
interface cbd_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              i_start;
    logic [2:0]        i_k;
    logic [1:0]        i_eta;
    logic [7:0]        i_nonce0;

    logic              o_prf_req;
    logic [7:0]        o_prf_nonce;
    logic              i_prf_ack;
    logic [63:0]       i_prf_data;
    logic              i_prf_valid;
    logic              o_prf_ready;

    logic [63:0]       o_cbd_ibytes;
    logic              o_cbd_ibytes_valid;
    logic [1:0]        o_cbd_eta;
    logic [47:0]       i_cbd_coeffs;
    logic              i_cbd_coeffs_valid;
    logic              i_cbd_done;

    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [47:0]       o_wr_data;

    logic              o_busy;
    logic              o_done;
    logic              o_err;

    modport master (
        input  i_start, i_k, i_eta, i_nonce0,
        output o_prf_req, o_prf_nonce, o_prf_ready,
        input  i_prf_ack, i_prf_data, i_prf_valid,
        output o_cbd_ibytes, o_cbd_ibytes_valid, o_cbd_eta,
        input  i_cbd_coeffs, i_cbd_coeffs_valid, i_cbd_done,
        output o_wr_en, o_wr_addr, o_wr_data,
        output o_busy, o_done, o_err
    );

    modport slave (
        output i_start, i_k, i_eta, i_nonce0,
        input  o_prf_req, o_prf_nonce, o_prf_ready,
        output i_prf_ack, i_prf_data, i_prf_valid,
        input  o_cbd_ibytes, o_cbd_ibytes_valid, o_cbd_eta,
        output i_cbd_coeffs, i_cbd_coeffs_valid, i_cbd_done,
        input  o_wr_en, o_wr_addr, o_wr_data,
        input  o_busy, o_done, o_err
    );
endinterface

// File: rtl/cbd_ctrl.sv
// Sequences K noise polynomials: PRF request, word forwarding into cbd, coefficient
// capture into RAM. Optional watchdog abort enabled by macro CBD_CTRL_WATCHDOG_EN.
module cbd_ctrl #(
    parameter int MAX_K    = 4,
    parameter int ADDR_W   = 6,
    parameter int WDOG_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    cbd_ctrl_if.master  bus
);

    localparam int PW = ADDR_W - 4;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_FEED = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_NEXT = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    function automatic logic [4:0] words_for(input logic [1:0] eta);
        if (eta == 2'd3) begin
            return 5'd24;
        end else begin
            return 5'd16;
        end
    endfunction

    logic [2:0]        state_q,   state_d;
    logic [2:0]        k_q,       k_d;
    logic [1:0]        eta_q,     eta_d;
    logic [7:0]        nonce_q,   nonce_d;
    logic [PW-1:0]     poly_q,    poly_d;
    logic [4:0]        word_q,    word_d;
    logic [4:0]        beat_q,    beat_d;
    logic              req_q,     req_d;
    logic              ready_q,   ready_d;
    logic [63:0]       ibytes_q,  ibytes_d;
    logic              ibv_q,     ibv_d;
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [47:0]       wr_data_q, wr_data_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              err_q,     err_d;
`ifdef CBD_CTRL_WATCHDOG_EN
    logic [15:0]       wdog_q,    wdog_d;
`endif

    logic start_ok_s;
    logic last_poly_s;
    logic accept_s;

    assign start_ok_s  = ((bus.i_eta == 2'd2) || (bus.i_eta == 2'd3)) &&
                         (bus.i_k != 3'd0) && ({29'd0, bus.i_k} <= 32'(MAX_K));
    assign last_poly_s = (32'(poly_q) + 32'd1) == {29'd0, k_q};
    assign accept_s    = (state_q == S_FEED) && bus.i_prf_valid && ready_q;

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        eta_d     = eta_q;
        nonce_d   = nonce_q;
        poly_d    = poly_q;
        word_d    = word_q;
        beat_d    = beat_q;
        ibytes_d  = ibytes_q;
        ibv_d     = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;
`ifdef CBD_CTRL_WATCHDOG_EN
        wdog_d    = wdog_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.i_start && start_ok_s) begin
                    k_d     = bus.i_k;
                    eta_d   = bus.i_eta;
                    nonce_d = bus.i_nonce0;
                    poly_d  = '0;
                    word_d  = 5'd0;
                    beat_d  = 5'd0;
                    err_d   = 1'b0;
                    state_d = S_REQ;
                end else if (bus.i_start) begin
                    err_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus.i_prf_ack) begin
                    state_d = S_FEED;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_FEED: begin
                if (accept_s) begin
                    ibytes_d = bus.i_prf_data;
                    ibv_d    = 1'b1;
                    word_d   = word_q + 5'd1;
                    if ((word_q + 5'd1) == words_for(eta_q)) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_FEED;
                    end
                end else begin
                    state_d = S_FEED;
                end
            end
            S_WAIT: begin
                if (bus.i_cbd_done) begin
                    state_d = S_NEXT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_NEXT: begin
                if (beat_q != 5'd16) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                word_d  = 5'd0;
                beat_d  = 5'd0;
                poly_d  = poly_q + {{(PW-1){1'b0}}, 1'b1};
                nonce_d = nonce_q + 8'd1;
                if (last_poly_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Beats beyond the sixteenth are dropped and flagged
        if (((state_q == S_FEED) || (state_q == S_WAIT)) && bus.i_cbd_coeffs_valid) begin
            if (beat_q < 5'd16) begin
                wr_en_d   = 1'b1;
                wr_data_d = bus.i_cbd_coeffs;
                wr_addr_d = {poly_q, beat_q[3:0]};
                beat_d    = beat_q + 5'd1;
            end else begin
                err_d     = 1'b1;
            end
        end else begin
            beat_d = beat_d;
        end

`ifdef CBD_CTRL_WATCHDOG_EN
        // Per-state cycle budget; expiry abandons the run without o_done
        if ((state_q == S_REQ) || (state_q == S_FEED) || (state_q == S_WAIT)) begin
            if (state_d != state_q) begin
                wdog_d = 16'd0;
            end else if (wdog_q == 16'(WDOG_CYC - 1)) begin
                wdog_d  = 16'd0;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                wdog_d = wdog_q + 16'd1;
            end
        end else begin
            wdog_d = 16'd0;
        end
`endif

        req_d   = (state_d == S_REQ);
        ready_d = (state_d == S_FEED) && (word_d < words_for(eta_d));
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= S_IDLE;
            k_q       <= 3'd0;
            eta_q     <= 2'd0;
            nonce_q   <= 8'd0;
            poly_q    <= '0;
            word_q    <= 5'd0;
            beat_q    <= 5'd0;
            req_q     <= 1'b0;
            ready_q   <= 1'b0;
            ibytes_q  <= 64'd0;
            ibv_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 48'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef CBD_CTRL_WATCHDOG_EN
            wdog_q    <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            eta_q     <= eta_d;
            nonce_q   <= nonce_d;
            poly_q    <= poly_d;
            word_q    <= word_d;
            beat_q    <= beat_d;
            req_q     <= req_d;
            ready_q   <= ready_d;
            ibytes_q  <= ibytes_d;
            ibv_q     <= ibv_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef CBD_CTRL_WATCHDOG_EN
            wdog_q    <= wdog_d;
`endif
        end
    end

    assign bus.o_prf_req          = req_q;
    assign bus.o_prf_nonce        = nonce_q;
    assign bus.o_prf_ready        = ready_q;
    assign bus.o_cbd_ibytes       = ibytes_q;
    assign bus.o_cbd_ibytes_valid = ibv_q;
    assign bus.o_cbd_eta          = eta_q;
    assign bus.o_wr_en            = wr_en_q;
    assign bus.o_wr_addr          = wr_addr_q;
    assign bus.o_wr_data          = wr_data_q;
    assign bus.o_busy             = busy_q;
    assign bus.o_done             = done_q;
    assign bus.o_err              = err_q;

endmodule

// File: tb/tb_cbd_ctrl.sv
// Randomized bench for cbd_ctrl: the driver plays PRF and cbd, pushing expected
// nonces, forwarded words and RAM writes into queues that a monitor pops.
module tb_cbd_ctrl;
    localparam int ADDR_W = 6;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    cbd_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    cbd_ctrl #(.MAX_K(4), .ADDR_W(ADDR_W), .WDOG_CYC(255)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int done_seen = 0;
    logic prev_req = 1'b0;

    logic [ADDR_W+47:0] exp_wr_q[$];
    logic [63:0]        exp_word_q[$];
    logic [7:0]         exp_nonce_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Monitor: pops expectations whenever the DUT presents an output
    always @(negedge clk) begin
        logic [ADDR_W+47:0] e;
        if (bus.o_done) done_seen++;
        if (rstn) begin
            if (bus.o_wr_en) begin
                if (exp_wr_q.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
                else begin
                    e = exp_wr_q.pop_front();
                    check("wr_addr", 64'(bus.o_wr_addr), 64'(e[ADDR_W+47:48]));
                    check("wr_data", 64'(bus.o_wr_data), 64'(e[47:0]));
                end
            end
            if (bus.o_cbd_ibytes_valid) begin
                if (exp_word_q.size() == 0) check("word_unexpected", 64'd1, 64'd0);
                else check("cbd_word", bus.o_cbd_ibytes, exp_word_q.pop_front());
            end
            if (bus.o_prf_req && !prev_req) begin
                if (exp_nonce_q.size() == 0) check("req_unexpected", 64'd1, 64'd0);
                else check("prf_nonce", 64'(bus.o_prf_nonce), 64'(exp_nonce_q.pop_front()));
            end
        end
        prev_req = bus.o_prf_req;
    end

    task automatic check_all_zero(input string name);
        check(name, 64'({bus.o_prf_req, bus.o_prf_nonce, bus.o_prf_ready, bus.o_cbd_ibytes_valid,
                         bus.o_cbd_eta, bus.o_wr_en, bus.o_wr_addr, bus.o_busy, bus.o_done,
                         bus.o_err}), 64'd0);
        check({name, "_data"}, bus.o_cbd_ibytes | 64'(bus.o_wr_data), 64'd0);
    endtask

    task automatic pulse_start(input int k, input int eta, input logic [7:0] n0);
        bus.i_start  = 1'b1;
        bus.i_k      = 3'(k);
        bus.i_eta    = 2'(eta);
        bus.i_nonce0 = n0;
        tick();
        bus.i_start  = 1'b0;
    endtask

    task automatic bad_start(input int k, input int eta);
        pulse_start(k, eta, 8'h00);
        tick(); tick();
        check("bad_start_busy", 64'(bus.o_busy), 64'd0);
        check("bad_start_err", 64'(bus.o_err), 64'd1);
    endtask

    // vmode: 0 always valid, 1 toggling, 2 random
    task automatic do_run(input int k, input int eta, input logic [7:0] n0, input int vmode,
                          input int beats0, input int beats1, input int abort_poly,
                          input bit withhold);
        int words;
        bit exp_err;
        int w;
        words   = (eta == 3) ? 24 : 16;
        exp_err = 1'b0;
        for (int p = 0; p < k; p++) exp_nonce_q.push_back(n0 + 8'(p));
        done_seen = 0;
        pulse_start(k, eta, n0);
        check("start_busy", 64'(bus.o_busy), 64'd1);
        check("start_err_clear", 64'(bus.o_err), 64'd0);
        check("cbd_eta", 64'(bus.o_cbd_eta), 64'(eta));
        for (int p = 0; p < k; p++) begin
            int idx;
            int cyc;
            int nb;
            bit done_sent;
            logic [63:0] d;
            logic [47:0] c;
            w = 0;
            while (!bus.o_prf_req && w < 30) begin tick(); w++; end
            check("req_seen", 64'(bus.o_prf_req), 64'd1);
            bus.i_prf_ack = 1'b1;
            tick();
            bus.i_prf_ack = 1'b0;
            check("req_drop", 64'(bus.o_prf_req), 64'd0);
            idx = 0;
            cyc = 0;
            d = {$urandom, $urandom};
            while (idx < words && cyc < 400) begin
                bit v;
                if (abort_poly == p && idx == 5) begin
                    bus.i_prf_valid = 1'b0;
                    #2;
                    rstn = 1'b0;
                    exp_wr_q.delete(); exp_word_q.delete(); exp_nonce_q.delete();
                    #1;
                    check_all_zero("abort_rst");
                    repeat (4) tick();
                    rstn = 1'b1;
                    repeat (10) tick();
                    check("abort_no_done", 64'(done_seen), 64'd0);
                    check("abort_idle", 64'(bus.o_busy), 64'd0);
                    return;
                end
                v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
                bus.i_prf_valid = v;
                bus.i_prf_data  = d;
                if (v && bus.o_prf_ready) begin
                    exp_word_q.push_back(d);
                    idx++;
                    d = {$urandom, $urandom};
                end
                tick();
                cyc++;
            end
            bus.i_prf_valid = 1'b0;
            check("ready_drop", 64'(bus.o_prf_ready), 64'd0);
            nb = (p == 0) ? beats0 : beats1;
            if (nb != 16) exp_err = 1'b1;
            done_sent = 1'b0;
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 2) == 0) tick();
                c = {16'($urandom), $urandom};
                bus.i_cbd_coeffs_valid = 1'b1;
                bus.i_cbd_coeffs = c;
                if (b < 16) exp_wr_q.push_back({ADDR_W'(p * 16 + b), c});
                if (b == nb - 1 && $urandom_range(0, 1) == 1 && !withhold) begin
                    bus.i_cbd_done = 1'b1;
                    done_sent = 1'b1;
                end
                tick();
                bus.i_cbd_coeffs_valid = 1'b0;
                bus.i_cbd_done = 1'b0;
            end
            if (withhold) begin
                repeat (300) tick();
`ifdef CBD_CTRL_WATCHDOG_EN
                check("wdog_idle", 64'(bus.o_busy), 64'd0);
                check("wdog_err", 64'(bus.o_err), 64'd1);
                check("wdog_no_done", 64'(done_seen), 64'd0);
                return;
`else
                check("no_wdog_busy", 64'(bus.o_busy), 64'd1);
`endif
            end
            if (!done_sent) begin
                bus.i_cbd_done = 1'b1;
                tick();
                bus.i_cbd_done = 1'b0;
            end
        end
        w = 0;
        while (done_seen == 0 && w < 20) begin tick(); w++; end
        repeat (3) tick();
        check("done_once", 64'(done_seen), 64'd1);
        check("end_err", 64'(bus.o_err), 64'(exp_err));
        check("end_busy", 64'(bus.o_busy), 64'd0);
        check("queues_drained", 64'(exp_wr_q.size() + exp_word_q.size() + exp_nonce_q.size()), 64'd0);
        exp_wr_q.delete(); exp_word_q.delete(); exp_nonce_q.delete();
    endtask

    initial begin
        rstn = 1'b0;
        bus.i_start = 1'b0; bus.i_k = 3'd0; bus.i_eta = 2'd0; bus.i_nonce0 = 8'd0;
        bus.i_prf_ack = 1'b0; bus.i_prf_data = 64'd0; bus.i_prf_valid = 1'b0;
        bus.i_cbd_coeffs = 48'd0; bus.i_cbd_coeffs_valid = 1'b0; bus.i_cbd_done = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rstn = 1'b1;
        tick();

        do_run(2, 2, 8'h10, 0, 16, 16, -1, 1'b0);
        do_run(3, 3, 8'h20, 1, 16, 16, -1, 1'b0);
        do_run(2, 2, 8'hFF, 2, 16, 16, -1, 1'b0);
        bad_start(2, 1);
        bad_start(0, 2);
        bad_start(5, 3);
        do_run(4, 3, 8'($urandom), 2, 16, 16, -1, 1'b0);
        do_run(2, 2, 8'h40, 2, 17, 16, -1, 1'b0);
        do_run(2, 3, 8'h50, 0, 15, 16, -1, 1'b0);
        do_run(2, 2, 8'h60, 0, 16, 16, 1, 1'b0);
        do_run(1, 2, 8'h70, 0, 16, 16, -1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cbd_ctrl.md
Name: cbd_ctrl

Overview:
Sequences generation of K noise polynomials through the cbd sampler. Per polynomial, the controller:
- requests a PRF output stream using an incrementing nonce;
- forwards exactly 16 (eta=2) or 24 (eta=3) 64-bit words into cbd;
- collects the 16 coefficient beats (48 bits, 16 x 3-bit coeffs each) into polynomial memory at {poly, beat} addresses.

It sits between the PRF/SHAKE front end and the noise-polynomial RAM. It is the only master of cbd's input port.

Parameters:
MAX_K, 4, maximum polynomials per run (i_k range 1..MAX_K)
ADDR_W, 6, write address width = clog2(MAX_K)+4
WDOG_CYC, 255, watchdog limit in cycles (used only with the optional feature)

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset, asynchronous, active-low
i_start  in  1  start pulse (honoured only in S_IDLE)
i_k  in  3  polynomial count, latched on start
i_eta  in  2  2 or 3, latched on start
i_nonce0  in  8  first nonce, latched on start
o_prf_req  out  1  PRF request, held until acked
o_prf_nonce  out  8  nonce for the current polynomial
i_prf_ack  in  1  PRF accepted request
i_prf_data  in  64  PRF output word
i_prf_valid  in  1  PRF word valid
o_prf_ready  out  1  controller accepts PRF word
o_cbd_ibytes  out  64  registered word to cbd
o_cbd_ibytes_valid  out  1  registered valid to cbd
o_cbd_eta  out  2  latched eta to cbd
i_cbd_coeffs  in  48  cbd coefficient beat
i_cbd_coeffs_valid  in  1  beat valid
i_cbd_done  in  1  cbd polynomial complete pulse
o_wr_en  out  1  RAM write strobe
o_wr_addr  out  ADDR_W  {poly_idx, beat_idx[3:0]}
o_wr_data  out  48  registered coefficient beat
o_busy  out  1  high outside S_IDLE
o_done  out  1  one-cycle run-complete pulse
o_err  out  1  sticky error flag

Behaviour:
Reset values:
- All outputs 0; state S_IDLE; all counters 0.
- An async reset mid-run aborts immediately. No partial o_done is produced.

Start:
- i_start in S_IDLE with i_eta in {2,3} and 1 <= i_k <= MAX_K: latch k, eta, nonce; clear o_err; go to S_REQ.
- Invalid i_eta or i_k: start rejected, stay in S_IDLE, set o_err.
- i_start outside S_IDLE: ignored.

FSM:
- S_REQ: o_prf_req=1, o_prf_nonce = nonce0 + poly_idx (mod 256). On i_prf_ack go to S_FEED; o_prf_req drops the next cycle.
- S_FEED:
  - o_prf_ready = (word_cnt < words), where words = 16 for eta=2 and 24 for eta=3.
  - A beat is accepted when i_prf_valid & o_prf_ready.
  - On acceptance, o_cbd_ibytes/o_cbd_ibytes_valid are registered one cycle later, and word_cnt increments.
  - On the last acceptance, go to S_WAIT.
  - A PRF valid without ready is held by the PRF (standard valid/ready).
- S_WAIT: o_prf_ready=0. On i_cbd_done go to S_NEXT.
- S_NEXT:
  - If beat_cnt != 16, set o_err.
  - Clear word_cnt and beat_cnt; increment poly_idx.
  - If poly_idx+1 == k, go to S_DONE; else go to S_REQ.
- S_DONE: o_done=1 for one cycle, then S_IDLE.

Coefficient capture:
- Active in S_FEED and S_WAIT.
- i_cbd_coeffs_valid with beat_cnt < 16 produces, one cycle later: o_wr_en=1, o_wr_data = i_cbd_coeffs, o_wr_addr = {poly_idx, beat_cnt}. beat_cnt then increments.
- A beat arriving with beat_cnt == 16 is dropped and sets o_err.
- Beats in any other state are ignored.

Simultaneous events:
- i_cbd_done in the same cycle as the final coeffs_valid: the beat is still written.
- o_cbd_ibytes_valid never asserts outside S_FEED or the cycle following it.

Optional Feature:
Macro CBD_CTRL_WATCHDOG_EN.
- Defined: a cycle counter runs in S_REQ, S_FEED and S_WAIT and clears on every state transition. Reaching WDOG_CYC sets o_err and forces S_IDLE without o_done; o_busy drops.
- Undefined: no counter; the controller waits indefinitely.

Test Plan:
1. eta=2, k=2, nonce0=0x10, PRF always valid, acked next cycle -> nonces 0x10, 0x11; 16 words forwarded per poly; 32 writes at addr 0x00..0x1F; one o_done; o_err=0.
2. eta=3, k=3, PRF valid toggling every other cycle -> 24 words per poly, no dropped or duplicated word; addrs 0..47; o_done after third i_cbd_done.
3. nonce0=0xFF, k=2 -> second nonce is 0x00 (wrap).
4. Start with i_eta=1, and separately with i_k=0 -> stays S_IDLE, o_busy=0, o_err=1; a following valid start clears o_err.
5. cbd emits 17 beats for poly 0 -> 16 writes, o_err=1; 15 beats -> o_err=1 at S_NEXT; run still completes.
6. Reset asserted mid-S_FEED of poly 1 -> all outputs 0 immediately, no o_done. With CBD_CTRL_WATCHDOG_EN and WDOG_CYC=255, i_cbd_done withheld -> o_err=1 and S_IDLE after 255 cycles in S_WAIT.
